operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage between instruction fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and drives the register file read indices. It captures the register file's one-cycle-late read data, bypassing any writeback that landed on the same edge as the read. It keeps a 32-entry busy scoreboard, so no instruction issues while a source or destination register has a write outstanding.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register index.
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept (combinational)
- in_instr  in  32  MIPS instruction word
- in_pc  in  32  instruction address
- rf_rindex0  out  5  register file read index 0 (combinational)
- rf_rindex1  out  5  register file read index 1 (combinational)
- rf_rout0  in  32  register file read data 0; valid the cycle after its index is presented
- rf_rout1  in  32  register file read data 1; valid the cycle after its index is presented
- wb_we  in  1  writeback write enable (same signal driving the register file)
- wb_windex  in  5  writeback index
- wb_win  in  32  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_instr  out  32  held instruction
- out_pc  out  32  held PC
- out_op0  out  32  rs operand (combinational from rf_rout0 / bypass)
- out_op1  out  32  rt operand (combinational from rf_rout1 / bypass)
- out_dst  out  5  decoded destination register
- out_dst_we  out  1  instruction writes out_dst

## Operation
- Sources: rs = instr[25:21], rt = instr[20:16]. Both are always treated as sources.
- Destination decode:
  - opcode 0 → rd = instr[15:11]
  - opcodes 0x08–0x0F and 0x20–0x25 → rt
  - 0x03 (JAL) → 31
  - all others → no write
  - dst 0 → out_dst_we = 0
- Scoreboard busy[31:0]; busy[0] is hardwired to 0.
  - clr[i] = wb_we && wb_windex == i.
  - A register is blocking if busy[i] && !clr[i].
- Accept condition: in_valid && !rst && (stage B empty || (out_valid && out_ready)) && rs, rt and a written dst are all non-blocking.
  - in_ready is the same expression without in_valid.
- On accept: busy[dst] is set if dst_we. If set and clear hit the same index in the same cycle, set wins.
- Stage B registers instr, pc, dst and dst_we on accept. out_valid = 1 the next cycle.
- On out fire with no accept, stage B empties.
- rf_rindex0/1 = in_instr rs/rt when accepting, otherwise stage B's rs/rt. This keeps rf_rout valid while stage B is held.
- Bypass registers (wb_we_q, wb_windex_q, wb_win_q) capture the wb port every cycle.
- out_op0 selection, in priority order (same rule for out_op1 with rt):
  - rs == 0 → 0
  - wb_we_q && wb_windex_q == rs → wb_win_q
  - otherwise → rf_rout0
- wb_we to register 0, or to a non-busy register, only updates the bypass registers.

## Timing
- Accept at cycle t → out_valid and operands at t+1. Throughput is 1 instruction per cycle.
- Back-pressure: out_valid && !out_ready holds all stage B outputs stable; rf_rindex keeps stage B's sources.
- Writeback to a blocking source in cycle t allows accept in t. The bypass supplies the value at t+1.
- Reset, synchronous, including mid-operation:
  - out_valid = 0, busy = 0, wb_we_q = 0
  - out_instr, out_pc, out_dst, out_dst_we = 0
  - in_ready = 0 while rst is high
  - a pending stage B instruction is discarded

## Structure
- Shared package holds the opcode constants (OP_RTYPE, OP_JAL, ranges 0x08–0x0F and 0x20–0x25) and the field bit positions, reused by execute/decode.
- One sub-module is natural: `dst_decode`, combinational, instr → dst and dst_we.
- The scoreboard and bypass stay inline.

## Test plan
- Reset, then ADDU $3,$1,$2 with regfile $1=5, $2=7 → out_valid at t+1, out_op0=5, out_op1=7, out_dst=3, busy[3]=1.
- ADDU $4,$3,$0 issued while busy[3] → in_ready=0. Then wb_we=1, idx 3, data 0x12 → accepted the same cycle; next cycle out_op0=0x12 via bypass, out_op1=0.
- out_ready=0 for 3 cycles with stage B full → outputs stable, rf_rindex holds stage B rs/rt, in_ready=0. Raising out_ready → next instruction accepted in that cycle.
- JAL, then LW $0,0($5) → out_dst=31 with we=1; then dst 0 with we=0 and busy unchanged.
- Busy[8] set and wb_we to index 8 in the same cycle as accepting ADDIU $8 → busy[8] remains 1.
- rst asserted while out_valid=1 and busy≠0 → next cycle out_valid=0, busy=0, in_ready=1 after release.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared MIPS decode constants for the operand-fetch/decode/execute stages.
// Field positions and destination-writing opcode ranges live here so every stage agrees.
package operand_fetch_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_IMM_LO  = 6'h08;
  localparam logic [5:0] OP_IMM_HI  = 6'h0F;
  localparam logic [5:0] OP_LOAD_LO = 6'h20;
  localparam logic [5:0] OP_LOAD_HI = 6'h25;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic        dst_we;
  } stage_t;

endpackage

// File: rtl/operand_fetch_dst_decode.sv
// Combinational destination-register decode: which register an instruction writes, if any.
// Writes to register 0 are reported as no write.
module dst_decode
  import operand_fetch_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_dst,
  output logic        o_dst_we
);

  logic [5:0]  w_op;
  logic [4:0]  w_dst;
  logic        w_hit;
  logic        w_unused_bits;

  assign w_op          = i_instr[OPC_MSB:OPC_LSB];
  assign w_unused_bits = ^i_instr[RD_LSB-1:0];

  always_comb begin
    w_dst = 5'd0;
    w_hit = 1'b0;
    if (w_op == OP_RTYPE) begin
      w_dst = i_instr[RD_MSB:RD_LSB];
      w_hit = 1'b1;
    end else if ((w_op >= OP_IMM_LO && w_op <= OP_IMM_HI) ||
                 (w_op >= OP_LOAD_LO && w_op <= OP_LOAD_HI)) begin
      w_dst = i_instr[RT_MSB:RT_LSB];
      w_hit = 1'b1;
    end else if (w_op == OP_JAL) begin
      w_dst = REG_RA;
      w_hit = 1'b1;
    end
  end

  assign o_dst    = w_dst;
  assign o_dst_we = w_hit && (w_dst != 5'd0);

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: busy scoreboard gating issue, register file read steering,
// and a one-entry writeback bypass covering the write that lands on the read edge.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_rindex0,
  output logic [4:0]  rf_rindex1,
  input  logic [31:0] rf_rout0,
  input  logic [31:0] rf_rout1,
  input  logic        wb_we,
  input  logic [4:0]  wb_windex,
  input  logic [31:0] wb_win,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_op0,
  output logic [31:0] out_op1,
  output logic [4:0]  out_dst,
  output logic        out_dst_we
);

  logic [31:0] r_busy;
  stage_t      r_stage;
  logic        r_out_valid;
  logic        r_wb_we_q;
  logic [4:0]  r_wb_windex_q;
  logic [31:0] r_wb_win_q;

  logic [4:0]  w_in_rs, w_in_rt, w_in_dst, w_b_rs, w_b_rt;
  logic        w_in_dst_we, w_stage_free, w_srcs_ok, w_accept;
  logic [31:0] w_clr, w_set, w_blocking, w_busy_next;

  dst_decode u_dst_decode (
    .i_instr  (in_instr),
    .o_dst    (w_in_dst),
    .o_dst_we (w_in_dst_we)
  );

  assign w_in_rs = in_instr[RS_MSB:RS_LSB];
  assign w_in_rt = in_instr[RT_MSB:RT_LSB];
  assign w_b_rs  = r_stage.instr[RS_MSB:RS_LSB];
  assign w_b_rt  = r_stage.instr[RT_MSB:RT_LSB];

  // A writeback in this cycle releases its register immediately; the bypass covers the data.
  assign w_clr      = wb_we ? (32'd1 << wb_windex) : 32'd0;
  assign w_blocking = r_busy & ~w_clr;
  assign w_srcs_ok  = !w_blocking[w_in_rs] && !w_blocking[w_in_rt] &&
                      !(w_in_dst_we && w_blocking[w_in_dst]);

  assign w_stage_free = !r_out_valid || out_ready;
  assign in_ready     = !rst && w_stage_free && w_srcs_ok;
  assign w_accept     = in_valid && in_ready;

  // Set is applied after clear so a same-index set wins.
  assign w_set       = (w_accept && w_in_dst_we) ? (32'd1 << w_in_dst) : 32'd0;
  assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~32'd1;

  assign rf_rindex0 = w_accept ? w_in_rs : w_b_rs;
  assign rf_rindex1 = w_accept ? w_in_rt : w_b_rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy        <= 32'd0;
      r_stage       <= '0;
      r_out_valid   <= 1'b0;
      r_wb_we_q     <= 1'b0;
      r_wb_windex_q <= 5'd0;
      r_wb_win_q    <= 32'd0;
    end else begin
      r_busy        <= w_busy_next;
      r_wb_we_q     <= wb_we;
      r_wb_windex_q <= wb_windex;
      r_wb_win_q    <= wb_win;
      if (w_accept) begin
        r_stage.instr  <= in_instr;
        r_stage.pc     <= in_pc;
        r_stage.dst    <= w_in_dst;
        r_stage.dst_we <= w_in_dst_we;
        r_out_valid    <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] sel_operand(input logic [4:0] idx, input logic [31:0] rf_data,
                                              input logic byp_we, input logic [4:0] byp_idx,
                                              input logic [31:0] byp_data);
    if (idx == 5'd0)
      return 32'd0;
    else if (byp_we && byp_idx == idx)
      return byp_data;
    else
      return rf_data;
  endfunction

  assign out_op0    = sel_operand(w_b_rs, rf_rout0, r_wb_we_q, r_wb_windex_q, r_wb_win_q);
  assign out_op1    = sel_operand(w_b_rt, rf_rout1, r_wb_we_q, r_wb_windex_q, r_wb_win_q);
  assign out_valid  = r_out_valid;
  assign out_instr  = r_stage.instr;
  assign out_pc     = r_stage.pc;
  assign out_dst    = r_stage.dst;
  assign out_dst_we = r_stage.dst_we;

endmodule
